// File: rtl/multiplexor_pkg.sv
// Shared constants for the channel multiplexor: operating mode encodings.
package multiplexor_pkg;
  localparam logic MODO_FIJO = 1'b0;
  localparam logic MODO_RR   = 1'b1;
endpackage

// File: rtl/multiplexor_canales_arbitro_rr.sv
// Rotating-priority encoder: grants the first requesting channel at or after
// i_puntero, wrapping modulo CANALES. Purely combinational.
module arbitro_rr #(
  parameter int CANALES = 4,
  localparam int SEL_W = $clog2(CANALES)
) (
  input  logic [CANALES-1:0] i_req,
  input  logic [SEL_W-1:0]   i_puntero,
  output logic               o_grant,
  output logic [SEL_W-1:0]   o_indice
);
  import multiplexor_pkg::*;

  int w_dist;
  int w_mejor;

  // Each requester's distance from the pointer in wrap order; smallest wins.
  always_comb begin
    o_grant  = 1'b0;
    o_indice = '0;
    w_dist   = 0;
    w_mejor  = CANALES;
    for (int i = 0; i < CANALES; i++) begin
      w_dist = (i >= int'(i_puntero)) ? (i - int'(i_puntero))
                                      : (i + CANALES - int'(i_puntero));
      if (i_req[i] && (w_dist < w_mejor)) begin
        w_mejor  = w_dist;
        o_grant  = 1'b1;
        o_indice = SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/multiplexor_canales.sv
// N-to-1 valid/ready stream multiplexor with fixed-select and round-robin modes
// and a single registered output stage.
module multiplexor_canales #(
  parameter int CANALES = 4,
  parameter int ANCHO = 8,
  localparam int SEL_W = $clog2(CANALES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CANALES*ANCHO-1:0] entradas,
  input  logic [CANALES-1:0]       validos,
  output logic [CANALES-1:0]       listos,
  input  logic                     modo,
  input  logic [SEL_W-1:0]         seleccion,
  output logic [ANCHO-1:0]         salida,
  output logic                     salida_valida,
  input  logic                     salida_lista,
  output logic [SEL_W-1:0]         canal_salida
);
  import multiplexor_pkg::*;

  // Handshake: a channel word moves when validos[i] && listos[i]; the output
  // word moves when salida_valida && salida_lista. listos never feeds validos.

  logic [ANCHO-1:0] r_salida;
  logic             r_valida;
  logic [SEL_W-1:0] r_canal;
  logic [SEL_W-1:0] r_puntero;

  logic [ANCHO-1:0] w_canales [CANALES];
  logic             w_carga;
  logic             w_rr_grant;
  logic [SEL_W-1:0] w_rr_indice;
  logic             w_fijo_grant;
  logic             w_grant;
  logic [SEL_W-1:0] w_indice;

  for (genvar g = 0; g < CANALES; g++) begin : g_desempaque
    assign w_canales[g] = entradas[g*ANCHO +: ANCHO];
  end

  arbitro_rr #(.CANALES(CANALES)) u_arbitro (
    .i_req     (validos),
    .i_puntero (r_puntero),
    .o_grant   (w_rr_grant),
    .o_indice  (w_rr_indice)
  );

  assign w_carga      = !r_valida || salida_lista;
  // Range check uses CANALES so non-power-of-two configurations never grant a ghost channel.
  assign w_fijo_grant = (int'(seleccion) < CANALES) && validos[seleccion];
  assign w_grant      = (modo == MODO_RR) ? w_rr_grant  : w_fijo_grant;
  assign w_indice     = (modo == MODO_RR) ? w_rr_indice : seleccion;

  always_comb begin
    listos = '0;
    if (!rst && w_carga && w_grant) begin
      listos[w_indice] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_salida  <= '0;
      r_valida  <= 1'b0;
      r_canal   <= '0;
      r_puntero <= '0;
    end else if (w_carga) begin
      if (w_grant) begin
        r_salida <= w_canales[w_indice];
        r_canal  <= w_indice;
        r_valida <= 1'b1;
        if (modo == MODO_RR) begin
          r_puntero <= (w_indice == SEL_W'(CANALES - 1)) ? '0 : w_indice + 1'b1;
        end
      end else begin
        r_valida <= 1'b0;
      end
    end
  end

  assign salida        = r_salida;
  assign salida_valida = r_valida;
  assign canal_salida  = r_canal;
endmodule

// File: tb/tb_multiplexor_canales.sv
// Bench for multiplexor_canales: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model and an output scoreboard.
module tb_multiplexor_canales;
  localparam int C = 4;
  localparam int W = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [C*W-1:0] entradas;
  logic [C-1:0]   validos;
  logic [C-1:0]   listos;
  logic           modo;
  logic [SW-1:0]  seleccion;
  logic [W-1:0]   salida;
  logic           salida_valida;
  logic           salida_lista;
  logic [SW-1:0]  canal_salida;

  multiplexor_canales #(.CANALES(C), .ANCHO(W)) dut (
    .clk(clk), .rst(rst), .entradas(entradas), .validos(validos),
    .listos(listos), .modo(modo), .seleccion(seleccion), .salida(salida),
    .salida_valida(salida_valida), .salida_lista(salida_lista),
    .canal_salida(canal_salida)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int          m_ptr = 0;
  int          m_ch  = 0;
  logic [W-1:0] m_sal = '0;
  bit          m_v   = 0;
  logic [W+SW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (just after a rising edge), check at the falling
  // edge, advance the model, and return just after the next rising edge.
  task automatic ciclo(input logic r, input logic m, input logic [SW-1:0] s,
                       input logic [C-1:0] v, input logic l, input logic [C*W-1:0] e);
    bit carga, g;
    int gi;
    logic [C-1:0] exp_listos;
    logic [W+SW-1:0] item;
    rst = r; modo = m; seleccion = s; validos = v; salida_lista = l; entradas = e;
    @(negedge clk);
    carga = !m_v || l;
    g = 0; gi = 0;
    if (m == 1'b0) begin
      gi = int'(s);
      g  = (gi < C) && v[gi];
    end else begin
      for (int k = C - 1; k >= 0; k--) begin
        if (v[(m_ptr + k) % C]) begin g = 1; gi = (m_ptr + k) % C; end
      end
    end
    exp_listos = (r || !carga || !g) ? '0 : (C'(1) << gi);
    check("listos", 32'(listos), 32'(exp_listos));
    check("salida_valida", 32'(salida_valida), 32'(m_v));
    check("salida", 32'(salida), 32'(m_sal));
    check("canal_salida", 32'(canal_salida), 32'(m_ch));
    if (!r && m_v && l) begin
      item = exp_q.pop_front();
      check("sb_word", 32'({canal_salida, salida}), 32'(item));
    end
    if (r) begin
      m_sal = '0; m_v = 0; m_ch = 0; m_ptr = 0;
      exp_q.delete();
    end else if (carga) begin
      if (g) begin
        m_sal = e[gi*W +: W]; m_ch = gi; m_v = 1;
        exp_q.push_back({SW'(gi), m_sal});
        if (m == 1'b1) m_ptr = (gi + 1) % C;
      end else begin
        m_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [C*W-1:0] e_fijo;
  int seq_rr [5] = '{0, 1, 2, 3, 0};
  int seq_gap [3] = '{3, 0, 3};

  initial begin
    rst = 1'b1; modo = 1'b0; seleccion = '0; validos = '0;
    salida_lista = 1'b0; entradas = '0;
    @(posedge clk);
    #1;
    ciclo(1, 0, 0, 4'h0, 0, '0);
    ciclo(1, 0, 0, 4'hF, 1, 32'hDEADBEEF);

    // fixed select, channel 2
    e_fijo = {8'h44, 8'hA5, 8'h22, 8'h11};
    ciclo(0, 0, 2, 4'hF, 1, e_fijo);
    check("fijo_salida", 32'(salida), 32'h0000_00A5);
    check("fijo_canal", 32'(canal_salida), 32'd2);

    // fixed select of an idle channel: word drains, nothing reloads
    ciclo(0, 0, 1, 4'b0001, 1, e_fijo);
    ciclo(0, 0, 1, 4'b0001, 1, e_fijo);
    check("fijo_vacio", 32'(salida_valida), 32'd0);

    // round robin from pointer 0 (fixed mode left it untouched)
    for (int i = 0; i < 5; i++) begin
      ciclo(0, 1, 0, 4'hF, 1, $urandom);
      check("rr_orden", 32'(canal_salida), 32'(seq_rr[i]));
    end

    // pointer now 1: gaps and wrap
    for (int i = 0; i < 3; i++) begin
      ciclo(0, 1, 0, 4'b1001, 1, $urandom);
      check("rr_huecos", 32'(canal_salida), 32'(seq_gap[i]));
    end

    // backpressure on a held word
    ciclo(0, 1, 0, 4'b0010, 1, {8'h00, 8'h00, 8'h5C, 8'h00});
    for (int i = 0; i < 3; i++) ciclo(0, 1, 0, 4'b0010, 0, $urandom);
    check("bp_estable", 32'(salida), 32'h0000_005C);
    ciclo(0, 1, 0, 4'b0010, 1, {8'h00, 8'h00, 8'h77, 8'h00});
    check("bp_recarga", 32'(salida), 32'h0000_0077);

    // reset while a word is stalled
    ciclo(0, 1, 0, 4'hF, 0, $urandom);
    ciclo(1, 1, 0, 4'hF, 0, $urandom);
    ciclo(0, 0, 0, 4'h0, 0, $urandom);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ciclo(($urandom_range(0, 59) == 0), (i / 100) % 2 == 1 ? 1'b1 : 1'($urandom_range(0, 1)),
            SW'($urandom_range(0, C - 1)), C'($urandom),
            ($urandom_range(0, 3) != 0), {$urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multiplexor_canales.md
Name: multiplexor_canales

Overview:
Parametrised N-to-1 stream multiplexor for carrying data words from several producer channels onto one consumer.
- Each input channel has a valid/ready handshake; the output is a single registered valid/ready stream.
- Two modes: fixed selection by an external select input, or round-robin arbitration among valid channels.
- Used wherever several sources share one datapath.

Parameters:
- CANALES, 4, number of input channels (>=2).
- ANCHO, 8, data width per channel in bits.
- SEL_W, $clog2(CANALES), derived localparam; width of channel indices (not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- entradas  input  CANALES*ANCHO  packed channel data; channel i occupies bits [i*ANCHO +: ANCHO].
- validos  input  CANALES  per-channel valid.
- listos  output  CANALES  per-channel ready (combinational).
- modo  input  1  0 = fixed select, 1 = round-robin.
- seleccion  input  SEL_W  channel index used in fixed mode.
- salida  output  ANCHO  registered output data.
- salida_valida  output  1  output valid (registered).
- salida_lista  input  1  downstream ready.
- canal_salida  output  SEL_W  index of the channel the current salida came from (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - salida=0, salida_valida=0, canal_salida=0, internal round-robin pointer=0.
  - Reset dominates every other event; any word held on the output is discarded.
  - listos=0 in every cycle where rst=1.
- Load condition: carga = !salida_valida || salida_lista. The output register accepts a new word only when carga=1.
- Grant is computed combinationally each cycle:
  - Fixed mode: candidate = seleccion. Grant only if seleccion < CANALES and validos[seleccion]=1. Out-of-range seleccion never grants.
  - Round-robin mode: search validos starting at index puntero, wrapping modulo CANALES. The first set bit is granted. If no validos are set, there is no grant.
- listos[i] = carga && grant && (granted index == i). At most one listos bit is high per cycle. A transfer on channel i occurs when validos[i] && listos[i].
- On a transfer from channel k at a clk edge:
  - salida <= entradas[k], canal_salida <= k, salida_valida <= 1.
  - Round-robin mode only: puntero <= (k+1) mod CANALES, wrapping from CANALES-1 to 0.
- If carga=1 and there is no grant: salida_valida <= 0; salida and canal_salida hold their values.
- If carga=0: salida, canal_salida and salida_valida hold. The output must stay stable while salida_valida && !salida_lista.
- Latency and throughput:
  - Input transfer to salida_valida: 1 cycle.
  - Sustained throughput: 1 word/cycle when salida_lista is held at 1.
  - A simultaneous output consume and input transfer in the same cycle is allowed and loses no cycle.
- Fixed mode never updates puntero.
- A modo change takes effect at the next grant evaluation. Words already registered are unaffected, and puntero is retained across mode changes.
- Channels not granted are not consumed; their validos and data must simply wait (standard valid/ready rule).
- There is a combinational path validos -> listos. There is no path from listos back to validos, so no loop.
- CANALES not a power of two: pointer wrap and the seleccion range check use CANALES, not 2^SEL_W.

Decomposition:
- Shared package multiplexor_pkg holds the mode constants MODO_FIJO=1'b0 and MODO_RR=1'b1.
- One natural sub-module: arbitro_rr, a purely combinational rotating-priority encoder.
  - Inputs: request vector, start pointer.
  - Outputs: grant flag, granted index.
  - Parametrised by CANALES.
- The top holds the output register, the pointer and the mode/select logic.

Test Plan:
- Reset mid-stream: salida_valida=1 with salida_lista=0, assert rst for 1 cycle -> next cycle salida_valida=0, salida=0, canal_salida=0, all listos=0.
- Fixed mode, CANALES=4: seleccion=2, validos=4'b1111, entradas ch2=8'hA5, salida_lista=1 -> listos=4'b0100; one cycle later salida=8'hA5, canal_salida=2; puntero unchanged (0).
- Fixed mode, unselected channel: seleccion=1, validos=4'b0001 -> listos=0 and salida_valida falls to 0 after the held word is consumed.
- Round-robin fairness: validos=4'b1111 held, salida_lista=1 -> canal_salida sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Round-robin with gaps and wrap: validos=4'b1001, puntero=1 -> grant 3, then grant 0, then grant 3.
- Backpressure: salida_lista=0 for 3 cycles with validos=4'b0010 -> listos=0, salida and canal_salida stable; on the salida_lista=1 cycle, listos[1]=1 and the next word loads the following cycle.
